// File: rtl/arbiter_grant_sink_if.sv
// Grant-sink bundle: the arbiter-facing four-phase handshake plus the
// clocked valid/ready grant stream. The sink takes the slave side; the
// arbiter/consumer environment takes the master side.
interface arbiter_grant_sink_if #(
  parameter int input_size = 8,
  parameter int fifo_depth = 4
);
  localparam int IDX_W = $clog2(input_size);
  localparam int CNT_W = $clog2(fifo_depth) + 1;

  logic                  req_in;
  logic [input_size-1:0] sel_in;
  logic                  ack_out;
  logic                  grant_valid;
  logic                  grant_ready;
  logic [IDX_W-1:0]      grant_idx;
  logic [CNT_W-1:0]      fifo_count;
  logic                  err;

  modport slave (
    input  req_in, sel_in, grant_ready,
    output ack_out, grant_valid, grant_idx, fifo_count, err
  );

  modport master (
    output req_in, sel_in, grant_ready,
    input  ack_out, grant_valid, grant_idx, fifo_count, err
  );
endinterface

// File: rtl/arbiter_grant_sink.sv
// arbiter_grant_sink: clocked consumer for the self-timed cascade arbiter.
// Synchronises req_in, completes the four-phase handshake with a registered
// ack_out, encodes the one-hot sel_in to a binary index and queues indices
// in a show-ahead FIFO exposed as a valid/ready grant stream.
// Optional macro ONEHOT_CHECK_EN: flags (sticky err) any pushed sel_in that
// is not exactly one-hot.
module arbiter_grant_sink #(
  parameter int input_size = 8,
  parameter int fifo_depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  arbiter_grant_sink_if.slave  bus
);
  localparam int IDX_W = $clog2(input_size);
  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state;
  logic             ack_r;
  logic             req_meta;
  logic             req_s;
  logic [IDX_W-1:0] enc_idx;
  logic             found;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [IDX_W-1:0] mem [fifo_depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Two-flop synchroniser for the asynchronous request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= bus.req_in;
      req_s    <= req_meta;
    end
  end

  // Lowest-set-bit encoder; sel_in is bundled data, stable while req_s=1
  always_comb begin
    enc_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < input_size; i++) begin
      if (bus.sel_in[i] && !found) begin
        enc_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
  end

  assign full  = (count == CNT_W'(fifo_depth));
  assign empty = (count == '0);
  assign push  = (state == IDLE) && req_s && !full;
  assign pop   = !empty && bus.grant_ready;

  // Handshake FSM; ack_out is registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ack_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_s && !full) begin
            state <= ACK;
            ack_r <= 1'b1;
          end
        end
        ACK: begin
          if (!req_s) begin
            state <= IDLE;
            ack_r <= 1'b0;
          end
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since reads are gated by empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_idx;
  end

  // FIFO pointers and occupancy counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ONEHOT_CHECK_EN
  logic [$clog2(input_size+1)-1:0] ones;
  logic                            sel_bad;
  logic                            err_r;

  // Population count of sel_in for the one-hot check
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < input_size; i++) begin
      ones = ones + $bits(ones)'(bus.sel_in[i]);
    end
  end

  assign sel_bad = (ones != $bits(ones)'(1));

  // Sticky error on a non-one-hot sel_in at the push instant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (push && sel_bad) begin
      err_r <= 1'b1;
`ifndef SYNTHESIS
      $error("arbiter_grant_sink: sel_in 0x%0h not one-hot at %0t", bus.sel_in, $time);
`endif
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ack_out     = ack_r;
  assign bus.grant_valid = !empty;
  assign bus.grant_idx   = empty ? '0 : mem[rd_ptr];
  assign bus.fifo_count  = count;
endmodule

// File: tb/tb_arbiter_grant_sink.sv
// Self-checking bench for arbiter_grant_sink (input_size=8, fifo_depth=4).
module tb_arbiter_grant_sink;
  localparam int N = 8;
  localparam int D = 4;
`ifdef ONEHOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] sel;
    int         idx;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   q[$];
  int   max_cnt = 0;
  bit   rand_ready = 1'b0;
  vec_t vecs[8];

  always #5 clk = ~clk;

  arbiter_grant_sink_if #(.input_size(N), .fifo_depth(D)) bus ();

  arbiter_grant_sink #(.input_size(N), .fifo_depth(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference encoding: isolate the lowest set bit arithmetically, take its log2
  function automatic int ref_idx(input logic [7:0] s);
    logic [7:0] low;
    low = s & (~s + 8'd1);
    return (low == 8'd0) ? 0 : $clog2(low);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.grant_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic lvl, input int bound, output int n);
    n = 0;
    while (bus.ack_out !== lvl && n < bound) begin
      tick();
      n++;
    end
    check("ack_reached", bus.ack_out, lvl);
  endtask

  task automatic handshake(input logic [7:0] sel, input bit chk_rise);
    int n;
    bus.sel_in = sel;
    bus.req_in = 1'b1;
    wait_ack(1'b1, 300, n);
    if (chk_rise) check("rise_latency", n, 3);
    bus.req_in = 1'b0;
    wait_ack(1'b0, 300, n);
    check("fall_latency", n, 3);
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0;
    bus.grant_ready = 1'b1;
    n = 0;
    while (bus.fifo_count != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", bus.fifo_count, 0);
    bus.grant_ready = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{sel: 8'h01, idx: 0, err: 1'b0};
    vecs[1] = '{sel: 8'h80, idx: 7, err: 1'b0};
    vecs[2] = '{sel: 8'h10, idx: 4, err: 1'b0};
    vecs[3] = '{sel: 8'h02, idx: 1, err: 1'b0};
    vecs[4] = '{sel: 8'h12, idx: 1, err: CHK};
    vecs[5] = '{sel: 8'h40, idx: 6, err: CHK};
    vecs[6] = '{sel: 8'h00, idx: 0, err: CHK};
    vecs[7] = '{sel: 8'hC0, idx: 6, err: CHK};

    rst = 1'b1;
    bus.req_in = 1'b0;
    bus.sel_in = '0;
    bus.grant_ready = 1'b0;

    // Scoreboard: one push per observed ack rise, pop when head is offered and accepted
    fork
      begin : monitor
        bit prev;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            q.delete();
            prev = 1'b0;
          end else begin
            if (bus.ack_out && !prev) q.push_back(ref_idx(bus.sel_in));
            check("fifo_count", bus.fifo_count, q.size());
            check("grant_valid", bus.grant_valid, q.size() != 0);
            if (q.size() != 0) check("grant_idx", bus.grant_idx, q[0]);
            if (q.size() > max_cnt) max_cnt = q.size();
            if (q.size() != 0 && bus.grant_ready) void'(q.pop_front());
            prev = bus.ack_out;
          end
        end
      end
    join_none

    repeat (3) tick();
    rst = 1'b0;
    check("rst_ack", bus.ack_out, 0);
    check("rst_valid", bus.grant_valid, 0);
    check("rst_idx", bus.grant_idx, 0);
    check("rst_count", bus.fifo_count, 0);
    check("rst_err", bus.err, 0);
    repeat (2) tick();

    // Single handshake
    handshake(8'b0000_0100, 1'b1);
    check("single_valid", bus.grant_valid, 1);
    check("single_idx", bus.grant_idx, 2);
    check("single_count", bus.fifo_count, 1);
    drain();

    // Fill to full, fifth request stalls until a slot frees
    handshake(8'h80, 1'b1);
    handshake(8'h01, 1'b1);
    handshake(8'h20, 1'b1);
    handshake(8'h08, 1'b1);
    check("full_count", bus.fifo_count, 4);
    bus.sel_in = 8'h40;
    bus.req_in = 1'b1;
    repeat (10) tick();
    check("stall_no_ack", bus.ack_out, 0);
    check("stall_head", bus.grant_idx, 7);
    bus.grant_ready = 1'b1;
    tick();
    bus.grant_ready = 1'b0;
    wait_ack(1'b1, 20, n);
    check("refill_count", bus.fifo_count, 4);
    check("refill_head", bus.grant_idx, 0);
    bus.req_in = 1'b0;
    wait_ack(1'b0, 20, n);
    drain();

    // Streaming with constant ready: occupancy never above one, pointers wrap
    max_cnt = 0;
    bus.grant_ready = 1'b1;
    for (int i = 0; i < 20; i++) handshake(8'(1 << (i % 8)), 1'b1);
    check("stream_max_le1", max_cnt <= 1, 1);
    drain();

    // Reset in ACK with two entries queued and req_in held high
    handshake(8'h02, 1'b1);
    bus.sel_in = 8'h20;
    bus.req_in = 1'b1;
    wait_ack(1'b1, 20, n);
    check("pre_rst_count", bus.fifo_count, 2);
    rst = 1'b1;
    #1;
    check("midrst_ack", bus.ack_out, 0);
    check("midrst_count", bus.fifo_count, 0);
    check("midrst_valid", bus.grant_valid, 0);
    repeat (2) tick();
    rst = 1'b0;
    wait_ack(1'b1, 20, n);
    check("post_rst_latency", n, 3);
    check("post_rst_count", bus.fifo_count, 1);
    check("post_rst_idx", bus.grant_idx, 5);
    bus.req_in = 1'b0;
    wait_ack(1'b0, 20, n);
    drain();

    // Table-driven encodings, including non-one-hot sel_in (err is sticky)
    for (int i = 0; i < 8; i++) begin
      handshake(vecs[i].sel, 1'b1);
      check("vec_idx", bus.grant_idx, vecs[i].idx);
      check("vec_err", bus.err, vecs[i].err);
      bus.grant_ready = 1'b1;
      tick();
      bus.grant_ready = 1'b0;
    end
    drain();

    // Randomised arbiter-style traffic with random consumer back-pressure
    rand_ready = 1'b1;
    for (int r = 0; r < 100; r++) begin
      handshake(8'(1 << $urandom_range(0, N - 1)), 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    check("final_model_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
